// File: rtl/weakbus_pkg.sv
// Shared definitions for the weakcore memory bus arbiter: bus field widths,
// FSM state encodings and a packed view of one master's request bundle.
package weakbus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [MASK_W-1:0] wr_mask;
        logic [DATA_W-1:0] data;
    } bus_req_t;

    // One-hot owner vector for a given FSM state; 00 when nobody owns the bus.
    function automatic logic [1:0] state_to_grant(input logic [1:0] st);
        logic [1:0] g;
        g = 2'b00;
        if (st == ST_GNT0) g = 2'b01;
        if (st == ST_GNT1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/weakbus_rr_pick.sv
// Two-way round-robin picker. On a tie the master that did not finish the
// previous transaction wins; a lone requester always wins.
module weakbus_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // Combinational one-hot winner selection from the request pair and history.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/weakbus_arbiter.sv
// Two-master, one-slave arbiter for the weakcore memory bus. Grants are
// round-robin and held until the slave acks; a watchdog aborts any
// transaction that waits too long so neither master can deadlock the bus.
module weakbus_arbiter
    import weakbus_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wr,
    input  logic [MASK_W-1:0] m0_wr_mask,
    input  logic [DATA_W-1:0] m0_out,
    output logic [DATA_W-1:0] m0_in,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wr,
    input  logic [MASK_W-1:0] m1_wr_mask,
    input  logic [DATA_W-1:0] m1_out,
    output logic [DATA_W-1:0] m1_in,
    output logic              m1_ack,
    output logic              m1_err,

    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wr,
    output logic [MASK_W-1:0] s_wr_mask,
    output logic [DATA_W-1:0] s_out,
    input  logic [DATA_W-1:0] s_in,
    input  logic              s_ack,

    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            last;
    logic            last_nxt;
    logic [TO_W-1:0] cnt;

    bus_req_t        m0_bus;
    bus_req_t        m1_bus;
    bus_req_t        sel;
    logic [1:0]      pick;
    logic            wd_hit;
    logic            done;
    logic            expired;
    logic            finish;

    assign m0_bus = '{req: m0_req, addr: m0_addr, wr: m0_wr, wr_mask: m0_wr_mask, data: m0_out};
    assign m1_bus = '{req: m1_req, addr: m1_addr, wr: m1_wr, wr_mask: m1_wr_mask, data: m1_out};

    weakbus_rr_pick u_pick (
        .req  ({m1_req, m0_req}),
        .last (last),
        .pick (pick)
    );

    // Route the owning master's request bundle; nothing is forwarded in IDLE.
    always_comb begin
        sel = '0;
        if (state == ST_GNT0) sel = m0_bus;
        if (state == ST_GNT1) sel = m1_bus;
    end

    // The watchdog limit depends only on the counter, so s_req never has a
    // combinational path from s_ack; a late s_ack still wins over the abort.
    assign wd_hit  = (state != ST_IDLE) && (cnt == TO_LAST);
    assign done    = sel.req && s_ack;
    assign expired = sel.req && wd_hit && !s_ack;
    assign finish  = done || expired;

    assign s_req     = sel.req && !wd_hit;
    assign s_addr    = sel.req ? sel.addr    : '0;
    assign s_wr      = sel.req ? sel.wr      : 1'b0;
    assign s_wr_mask = sel.req ? sel.wr_mask : '0;
    assign s_out     = sel.req ? sel.data    : '0;

    assign m0_ack = (state == ST_GNT0) && finish;
    assign m0_err = (state == ST_GNT0) && expired;
    assign m0_in  = ((state == ST_GNT0) && done) ? s_in : '0;
    assign m1_ack = (state == ST_GNT1) && finish;
    assign m1_err = (state == ST_GNT1) && expired;
    assign m1_in  = ((state == ST_GNT1) && done) ? s_in : '0;

    assign grant = state_to_grant(state);
    assign busy  = (state != ST_IDLE);

    // Next owner and round-robin history; a dropped request leaves history alone.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (pick[0])      state_nxt = ST_GNT0;
                else if (pick[1]) state_nxt = ST_GNT1;
            end
            ST_GNT0, ST_GNT1: begin
                if (!sel.req) begin
                    state_nxt = ST_IDLE;
                end else if (finish) begin
                    state_nxt = ST_IDLE;
                    last_nxt  = (state == ST_GNT1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM and history registers; last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Watchdog counter: held at zero in IDLE so each grant starts counting from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == ST_IDLE) begin
            cnt <= '0;
        end else if (!s_ack) begin
            cnt <= cnt + TO_W'(1);
        end
    end

endmodule

// File: tb/tb_weakbus_arbiter.sv
// Testbench for weakbus_arbiter: directed scenarios followed by a randomized
// run, all outputs compared every cycle against a transaction-level model.
module tb_weakbus_arbiter;

    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] data;
    } mdrv_t;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_wr, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_out, m0_in;
    logic [3:0]  m0_wr_mask;
    logic        m1_req, m1_wr, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_out, m1_in;
    logic [3:0]  m1_wr_mask;
    logic        s_req, s_wr, s_ack;
    logic [31:0] s_addr, s_out, s_in;
    logic [3:0]  s_wr_mask;
    logic [1:0]  grant;
    logic        busy;

    int vectors;
    int miscompares;

    mdrv_t d0, d1;

    // Reference model: who owns the bus (-1 none), cycles waited, last finisher.
    int own;
    int waited;
    int last_m;

    logic [1:0]  e_grant;
    logic        e_busy, e_sreq, e_swr;
    logic [31:0] e_saddr, e_sout;
    logic [3:0]  e_smask;
    logic        e_ack0, e_err0, e_ack1, e_err1;
    logic [31:0] e_in0, e_in1;
    logic        e_done, e_to;

    weakbus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_wr      (m0_wr),
        .m0_wr_mask (m0_wr_mask),
        .m0_out     (m0_out),
        .m0_in      (m0_in),
        .m0_ack     (m0_ack),
        .m0_err     (m0_err),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_wr      (m1_wr),
        .m1_wr_mask (m1_wr_mask),
        .m1_out     (m1_out),
        .m1_in      (m1_in),
        .m1_ack     (m1_ack),
        .m1_err     (m1_err),
        .s_req      (s_req),
        .s_addr     (s_addr),
        .s_wr       (s_wr),
        .s_wr_mask  (s_wr_mask),
        .s_out      (s_out),
        .s_in       (s_in),
        .s_ack      (s_ack),
        .grant      (grant),
        .busy       (busy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input mdrv_t a, input mdrv_t b, input logic ack, input logic [31:0] sin);
        d0 = a;
        d1 = b;
        m0_req = a.req; m0_addr = a.addr; m0_wr = a.wr; m0_wr_mask = a.mask; m0_out = a.data;
        m1_req = b.req; m1_addr = b.addr; m1_wr = b.wr; m1_wr_mask = b.mask; m1_out = b.data;
        s_ack = ack;
        s_in  = sin;
    endtask

    task automatic modelReset();
        own    = -1;
        waited = 0;
        last_m = 1;
    endtask

    // Expected outputs for the current cycle from the model and live inputs.
    task automatic computeExpected();
        mdrv_t cur;
        logic  hit;
        e_grant = 2'b00; e_busy = 1'b0; e_sreq = 1'b0; e_swr = 1'b0;
        e_saddr = '0; e_sout = '0; e_smask = '0;
        e_ack0 = 1'b0; e_err0 = 1'b0; e_in0 = '0;
        e_ack1 = 1'b0; e_err1 = 1'b0; e_in1 = '0;
        e_done = 1'b0; e_to = 1'b0;
        if (own >= 0) begin
            cur     = (own == 0) ? d0 : d1;
            e_grant = (own == 0) ? 2'b01 : 2'b10;
            e_busy  = 1'b1;
            hit     = (waited == TIMEOUT - 1);
            e_done  = cur.req && s_ack;
            e_to    = cur.req && hit && !s_ack;
            if (cur.req) begin
                e_sreq  = !hit;
                e_saddr = cur.addr;
                e_swr   = cur.wr;
                e_smask = cur.mask;
                e_sout  = cur.data;
            end
            if (own == 0) begin
                e_ack0 = e_done || e_to;
                e_err0 = e_to;
                e_in0  = e_done ? s_in : 32'h0;
            end else begin
                e_ack1 = e_done || e_to;
                e_err1 = e_to;
                e_in1  = e_done ? s_in : 32'h0;
            end
        end
    endtask

    task automatic modelUpdate();
        mdrv_t cur;
        if (own < 0) begin
            if (d0.req && d1.req) own = (last_m == 0) ? 1 : 0;
            else if (d0.req)      own = 0;
            else if (d1.req)      own = 1;
            waited = 0;
        end else begin
            cur = (own == 0) ? d0 : d1;
            if (!cur.req) begin
                own = -1;
            end else if (e_done || e_to) begin
                last_m = own;
                own    = -1;
            end else begin
                waited++;
            end
        end
    endtask

    task automatic checkOutput();
        #1;
        computeExpected();
        checkOne("grant",     32'(grant),     32'(e_grant));
        checkOne("busy",      32'(busy),      32'(e_busy));
        checkOne("s_req",     32'(s_req),     32'(e_sreq));
        checkOne("s_addr",    s_addr,         e_saddr);
        checkOne("s_wr",      32'(s_wr),      32'(e_swr));
        checkOne("s_wr_mask", 32'(s_wr_mask), 32'(e_smask));
        checkOne("s_out",     s_out,          e_sout);
        checkOne("m0_ack",    32'(m0_ack),    32'(e_ack0));
        checkOne("m0_err",    32'(m0_err),    32'(e_err0));
        checkOne("m0_in",     m0_in,          e_in0);
        checkOne("m1_ack",    32'(m1_ack),    32'(e_ack1));
        checkOne("m1_err",    32'(m1_err),    32'(e_err1));
        checkOne("m1_in",     m1_in,          e_in1);
    endtask

    task automatic tick();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    function automatic mdrv_t mkReq(input logic [31:0] addr, input logic wr, input logic [3:0] mask, input logic [31:0] data);
        mdrv_t n;
        n.req = 1'b1; n.addr = addr; n.wr = wr; n.mask = mask; n.data = data;
        return n;
    endfunction

    function automatic mdrv_t nextDrive(input mdrv_t cur, input logic acked);
        mdrv_t n;
        n = cur;
        if (!cur.req || acked) begin
            if ($urandom_range(0, 2) == 0)
                n = mkReq($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            else
                n = '0;
        end else if ($urandom_range(0, 19) == 0) begin
            n.req = 1'b0;
        end
        return n;
    endfunction

    localparam logic [1:0] FAIR_SEQ [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    initial begin
        mdrv_t none, r0, r1;
        vectors     = 0;
        miscompares = 0;
        none        = '0;
        modelReset();

        // Reset: outputs stay 0 even with requests and an ack present.
        rst = 1'b0;
        applyStimulus(mkReq(32'h40, 1'b1, 4'hF, 32'h1), mkReq(32'h80, 1'b0, 4'h0, 32'h0), 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput();
        @(negedge clk);
        applyStimulus(none, none, 1'b0, 32'h0);
        rst = 1'b1;

        // m0 read at 0x100, slave acks one cycle after s_req.
        $display("[TB] m0 read");
        applyStimulus(mkReq(32'h100, 1'b0, 4'h0, 32'h0), none, 1'b0, 32'h0);
        checkOutput(); checkOne("t1_grant_c0", 32'(grant), 32'h0);
        tick();
        checkOutput(); checkOne("t1_grant_c1", 32'(grant), 32'h1);
        tick();
        applyStimulus(d0, none, 1'b1, 32'hDEAD_BEEF);
        checkOutput();
        checkOne("t1_m0_ack", 32'(m0_ack), 32'h1);
        checkOne("t1_m0_in", m0_in, 32'hDEAD_BEEF);
        checkOne("t1_m1_ack", 32'(m1_ack), 32'h0);
        tick();
        applyStimulus(none, none, 1'b0, 32'h0);
        checkOutput(); tick();

        // m1 write: s_* visible only while grant=10.
        $display("[TB] m1 write");
        applyStimulus(none, mkReq(32'h2000, 1'b1, 4'b0011, 32'h0000_ABCD), 1'b0, 32'h0);
        checkOutput();
        checkOne("t2_idle_s_wr", 32'(s_wr), 32'h0);
        checkOne("t2_idle_s_out", s_out, 32'h0);
        tick();
        checkOutput();
        checkOne("t2_grant", 32'(grant), 32'h2);
        checkOne("t2_s_wr", 32'(s_wr), 32'h1);
        checkOne("t2_s_mask", 32'(s_wr_mask), 32'h3);
        checkOne("t2_s_out", s_out, 32'h0000_ABCD);
        checkOne("t2_s_addr", s_addr, 32'h2000);
        tick();
        applyStimulus(none, d1, 1'b1, 32'h0);
        checkOutput(); checkOne("t2_m1_ack", 32'(m1_ack), 32'h1);
        tick();
        applyStimulus(none, none, 1'b0, 32'h0);
        checkOutput(); checkOne("t2_after_s_addr", s_addr, 32'h0);
        tick();

        // Watchdog: slave never acks, m1 waits behind m0.
        $display("[TB] watchdog abort");
        applyStimulus(mkReq(32'h300, 1'b0, 4'h0, 32'h0), none, 1'b0, 32'h5555_5555);
        checkOutput(); tick();
        applyStimulus(d0, mkReq(32'h400, 1'b0, 4'h0, 32'h0), 1'b0, 32'h5555_5555);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            checkOutput(); tick();
        end
        checkOutput();
        checkOne("t3_m0_ack", 32'(m0_ack), 32'h1);
        checkOne("t3_m0_err", 32'(m0_err), 32'h1);
        checkOne("t3_m0_in", m0_in, 32'h0);
        checkOne("t3_s_req", 32'(s_req), 32'h0);
        tick();
        applyStimulus(none, d1, 1'b0, 32'h0);
        checkOutput(); checkOne("t3_busy_after", 32'(busy), 32'h0);
        tick();
        checkOutput(); checkOne("t3_m1_grant", 32'(grant), 32'h2);
        tick();
        applyStimulus(none, d1, 1'b1, 32'h7);
        checkOutput(); tick();
        applyStimulus(none, none, 1'b0, 32'h0);
        checkOutput(); tick();

        // s_ack on the last allowed cycle wins over the abort.
        $display("[TB] ack at watchdog limit");
        applyStimulus(mkReq(32'h500, 1'b0, 4'h0, 32'h0), none, 1'b0, 32'h0);
        checkOutput(); tick();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            checkOutput(); tick();
        end
        applyStimulus(d0, none, 1'b1, 32'h1234_5678);
        checkOutput();
        checkOne("t4_m0_ack", 32'(m0_ack), 32'h1);
        checkOne("t4_m0_err", 32'(m0_err), 32'h0);
        checkOne("t4_m0_in", m0_in, 32'h1234_5678);
        tick();
        applyStimulus(none, none, 1'b0, 32'h0);
        checkOutput(); tick();

        // Asynchronous reset in the middle of a GNT1 transaction.
        $display("[TB] reset during grant");
        applyStimulus(none, mkReq(32'h600, 1'b0, 4'h0, 32'h0), 1'b0, 32'h0);
        checkOutput(); tick();
        checkOutput(); checkOne("t5_s_req_before", 32'(s_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        checkOne("t5_s_req_reset", 32'(s_req), 32'h0);
        checkOne("t5_m1_ack_reset", 32'(m1_ack), 32'h0);
        checkOne("t5_grant_reset", 32'(grant), 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;

        // Fairness after reset: both held, zero-wait slave, m0 wins first.
        $display("[TB] fairness");
        applyStimulus(mkReq(32'h700, 1'b0, 4'h0, 32'h0), mkReq(32'h800, 1'b0, 4'h0, 32'h0), 1'b1, 32'hA5A5_A5A5);
        for (int i = 0; i < 8; i++) begin
            checkOutput();
            checkOne("t6_fair_grant", 32'(grant), 32'(FAIR_SEQ[i]));
            tick();
        end
        applyStimulus(none, none, 1'b0, 32'h0);
        checkOutput(); tick();

        // Randomized traffic with holding masters and a random slave.
        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            r0 = nextDrive(d0, e_ack0);
            r1 = nextDrive(d1, e_ack1);
            applyStimulus(r0, r1, ($urandom_range(0, 2) == 0), $urandom);
            checkOutput();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
